// File: rtl/data_sram_resp.sv
// Data-memory responder for the five-stage CPU: byte-lane stores, registered loads,
// and an optional fixed number of load wait states signalled through stallreq.
module data_sram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_sram_resp: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  logic [31:0]           r_mem [DEPTH];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_rdata;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_idle;
  logic                  w_store;
  logic                  w_load;
  logic                  w_unused_addr;

  assign w_idx         = data_sram_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};
  assign w_idle        = (r_state == S_IDLE);
  assign w_store       = w_idle && data_sram_en && (data_sram_wen != 4'h0);
  assign w_load        = w_idle && data_sram_en && (data_sram_wen == 4'h0);

  // Only state, en and wen feed the stall path, so addr/wdata cannot glitch it.
  assign stallreq        = (r_state == S_WAIT) || (w_load && (WAIT_CYCLES != 0));
  assign data_sram_rdata = r_rdata;

  // Array is never cleared; reset only blocks a write landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // The acceptance cycle counts as the first stall cycle, so WAIT lasts N-1 cycles:
  // the counter starts at N-1 and DONE follows once it has counted down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            if (WAIT_CYCLES == 0) begin
              r_rdata <= r_mem[w_idx];
            end else begin
              r_idx   <= w_idx;
              r_cnt   <= LP_CNT_INIT;
              r_state <= (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_rdata <= r_mem[r_idx];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: one zero-wait instance and one three-wait instance,
// each compared against a word-array reference model with cycle-level expectations.
module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
  logic        stall0, stall3;

  data_sram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0),
    .data_sram_rdata(rdata0), .stallreq(stall0));

  data_sram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3),
    .data_sram_rdata(rdata3), .stallreq(stall3));

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m0 [int];
  logic [31:0] m3 [int];
  logic [31:0] x0, x3;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] w,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One request cycle on the zero-wait instance, checked the cycle after.
  task automatic op0(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    int k;
    en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    #1;
    nvec++;
    if (stall0 !== 1'b0) begin
      nerr++; $display("FAIL op0_stall got=%b want=0 addr=%h", stall0, a);
    end
    if (e) begin
      k = widx(a);
      if (w != 4'h0) m0[k] = merge(m0.exists(k) ? m0[k] : 'x, w, d);
      else           x0 = m0.exists(k) ? m0[k] : 'x;
    end
    step;
    en0 = 1'b0;
    nvec++;
    if (rdata0 !== x0) begin
      nerr++; $display("FAIL op0_rdata got=%h want=%h addr=%h", rdata0, x0, a);
    end
  endtask

  task automatic store3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int k;
    en3 = 1'b1; wen3 = w; addr3 = a; wdata3 = d;
    #1;
    nvec++;
    if (stall3 !== 1'b0) begin
      nerr++; $display("FAIL store3_stall got=%b want=0", stall3);
    end
    k = widx(a);
    m3[k] = merge(m3.exists(k) ? m3[k] : 'x, w, d);
    step;
    en3 = 1'b0;
    nvec++;
    if (rdata3 !== x3) begin
      nerr++; $display("FAIL store3_rdata got=%h want=%h", rdata3, x3);
    end
  endtask

  // Load held for four cycles: stall in the first three, DONE in the fourth.
  task automatic load3(input logic [31:0] a);
    logic [31:0] nx;
    int k;
    k = widx(a);
    nx = m3.exists(k) ? m3[k] : 'x;
    en3 = 1'b1; wen3 = 4'h0; addr3 = a; wdata3 = $urandom;
    for (int c = 0; c < 4; c++) begin
      #1;
      nvec++;
      if (stall3 !== (c < 3)) begin
        nerr++; $display("FAIL load3_stall cyc=%0d got=%b want=%b", c, stall3, (c < 3));
      end
      nvec++;
      if (rdata3 !== x3) begin
        nerr++; $display("FAIL load3_early cyc=%0d got=%h want=%h", c, rdata3, x3);
      end
      step;
    end
    en3 = 1'b0;
    x3 = nx;
    #1;
    nvec++;
    if (rdata3 !== x3 || stall3 !== 1'b0) begin
      nerr++; $display("FAIL load3_result got=%h/%b want=%h/0", rdata3, stall3, x3);
    end
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
    en3 = 0; wen3 = 0; addr3 = 0; wdata3 = 0;
    x0 = 32'h0; x3 = 32'h0;
    for (int c = 0; c < 5; c++) begin
      step;
      if (c == 1) rst = 1'b0;
      nvec++;
      if (rdata0 !== 32'h0 || rdata3 !== 32'h0 || stall0 !== 1'b0 || stall3 !== 1'b0) begin
        nerr++;
        $display("FAIL reset cyc=%0d got=%h/%h/%b/%b want=0", c, rdata0, rdata3, stall0, stall3);
      end
    end
  endtask

  task automatic test_full_word;
    op0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    op0(1'b1, 4'h0, 32'h10, 32'h0);
    nvec++;
    if (rdata0 !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL full_word got=%h want=deadbeef", rdata0);
    end
  endtask

  task automatic test_byte_lanes;
    op0(1'b1, 4'hF, 32'h20, 32'h11223344);
    op0(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    op0(1'b1, 4'h0, 32'h20, 32'h0);
    nvec++;
    if (rdata0 !== 32'h11BB33DD) begin
      nerr++; $display("FAIL byte_lanes got=%h want=11bb33dd", rdata0);
    end
  endtask

  task automatic test_alias_hold;
    op0(1'b1, 4'hF, 32'h1004, 32'h5A5A5A5A);
    op0(1'b1, 4'h0, 32'h0004, 32'h0);
    for (int c = 0; c < 6; c++) begin
      nvec++;
      if (rdata0 !== 32'h5A5A5A5A) begin
        nerr++; $display("FAIL alias_hold cyc=%0d got=%h want=5a5a5a5a", c, rdata0);
      end
      op0(1'b0, 4'h0, $urandom, $urandom);
    end
  endtask

  task automatic test_random0;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) op0(1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom);
    for (int i = 0; i < 200; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 1)) << 12);
      case ($urandom_range(0, 3))
        0:       op0(1'b0, 4'($urandom), a, $urandom);
        1:       op0(1'b1, 4'($urandom_range(1, 15)), a, $urandom);
        default: op0(1'b1, 4'h0, a, $urandom);
      endcase
    end
  endtask

  task automatic test_wait_states;
    store3(4'hF, 32'h40, 32'hCAFEF00D);
    load3(32'h40);
    nvec++;
    if (rdata3 !== 32'hCAFEF00D) begin
      nerr++; $display("FAIL wait_states got=%h want=cafef00d", rdata3);
    end
  endtask

  task automatic test_reset_mid_wait;
    store3(4'hF, 32'h80, 32'h12345678);
    en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h80;
    #1;
    nvec++;
    if (stall3 !== 1'b1) begin
      nerr++; $display("FAIL rmw_accept got=%b want=1", stall3);
    end
    step;
    rst = 1'b1;
    #1;
    nvec++;
    if (stall3 !== 1'b1) begin
      nerr++; $display("FAIL rmw_wait got=%b want=1", stall3);
    end
    step;
    rst = 1'b0; en3 = 1'b0;
    x0 = 32'h0; x3 = 32'h0;
    #1;
    nvec++;
    if (stall3 !== 1'b0 || rdata3 !== 32'h0 || rdata0 !== 32'h0) begin
      nerr++; $display("FAIL rmw_cleared got=%b/%h/%h want=0/0/0", stall3, rdata3, rdata0);
    end
    step;
    nvec++;
    if (stall3 !== 1'b0 || rdata3 !== 32'h0) begin
      nerr++; $display("FAIL rmw_idle got=%b/%h want=0/0", stall3, rdata3);
    end
    load3(32'h80);
    nvec++;
    if (rdata3 !== 32'h12345678) begin
      nerr++; $display("FAIL rmw_reload got=%h want=12345678", rdata3);
    end
  endtask

  task automatic test_random3;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) store3(4'hF, 32'h300 + 32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      a = 32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin
          en3 = 1'b0; addr3 = $urandom; wdata3 = $urandom;
          #1;
          nvec++;
          if (stall3 !== 1'b0) begin
            nerr++; $display("FAIL idle3_stall got=%b want=0", stall3);
          end
          step;
          nvec++;
          if (rdata3 !== x3) begin
            nerr++; $display("FAIL idle3_rdata got=%h want=%h", rdata3, x3);
          end
        end
        1:       store3(4'($urandom_range(1, 15)), a, $urandom);
        default: load3(a);
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset;
    test_full_word;
    test_byte_lanes;
    test_alias_hold;
    test_random0;
    test_wait_states;
    test_reset_mid_wait;
    test_random3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
